// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-thread register file with pending-writer scoreboard and exception capture registers
module regfile_scoreboard #(
  parameter int THR = 4,
  parameter int NREG = 32,
  parameter int DATA_W = 32,
  parameter int ROB_ID_W = 4,
  parameter int PC_W = 32,
  parameter int XADDR_W = 32,
  parameter int XTYPE_W = 2,
  localparam int THR_W = $clog2(THR),
  localparam int REG_W = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [THR-1:0]      flush_pipeline,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [REG_W-1:0]    wr_dest,
  input  logic [ROB_ID_W-1:0] wr_instr_id,
  input  logic [THR_W-1:0]    wr_thread_id,
  input  logic                xcpt_valid,
  input  logic [XTYPE_W-1:0]  xcpt_type,
  input  logic [PC_W-1:0]     xcpt_pc,
  input  logic [XADDR_W-1:0]  xcpt_addr,
  input  logic [THR_W-1:0]    xcpt_thread_id,
  input  logic                alloc_valid,
  input  logic [REG_W-1:0]    alloc_dest,
  input  logic [ROB_ID_W-1:0] alloc_instr_id,
  input  logic [THR_W-1:0]    alloc_thread_id,
  input  logic [THR_W-1:0]    rd_thread_id,
  input  logic [REG_W-1:0]    rd_src1_addr,
  input  logic [REG_W-1:0]    rd_src2_addr,
  output logic [DATA_W-1:0]   rd_src1_data,
  output logic [DATA_W-1:0]   rd_src2_data,
  output logic                rd_src1_pending,
  output logic                rd_src2_pending,
  output logic [ROB_ID_W-1:0] rd_src1_rob_id,
  output logic [ROB_ID_W-1:0] rd_src2_rob_id,
  output logic                rm_valid,
  output logic [PC_W-1:0]     rm_pc,
  output logic [XADDR_W-1:0]  rm_addr,
  output logic [XTYPE_W-1:0]  rm_type,
  input  logic [THR-1:0]      rm_clear
);
  logic [DATA_W-1:0]   regs  [THR][NREG];
  logic [ROB_ID_W-1:0] owner [THR][NREG];
  logic [NREG-1:0]     pend  [THR];
  logic [THR-1:0]      rmv;
  logic [PC_W-1:0]     rmpc  [THR];
  logic [XADDR_W-1:0]  rmaddr[THR];
  logic [XTYPE_W-1:0]  rmtype[THR];
  logic hit1, hit2;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < THR; t++) begin
        for (int r = 0; r < NREG; r++) begin
          regs[t][r] <= '0;
          owner[t][r] <= '0;
        end
        pend[t] <= '0;
        rmpc[t] <= '0;
        rmaddr[t] <= '0;
        rmtype[t] <= '0;
      end
      rmv <= '0;
    end else begin
      if (wr_en && wr_dest != '0) regs[wr_thread_id][wr_dest] <= wr_data;
      for (int t = 0; t < THR; t++) begin
        // r0 is never touched so its pend bit stays 0 from reset
        for (int r = 1; r < NREG; r++) begin
          if (flush_pipeline[t]) pend[t][r] <= 1'b0;
          else if (alloc_valid && alloc_thread_id == THR_W'(t) && alloc_dest == REG_W'(r)) begin
            pend[t][r] <= 1'b1;
            owner[t][r] <= alloc_instr_id;
          end else if (wr_en && wr_thread_id == THR_W'(t) && wr_dest == REG_W'(r) && owner[t][r] == wr_instr_id)
            pend[t][r] <= 1'b0;
        end
        if (xcpt_valid && xcpt_thread_id == THR_W'(t)) begin
          rmv[t] <= 1'b1;
          rmpc[t] <= xcpt_pc;
          rmaddr[t] <= xcpt_addr;
          rmtype[t] <= xcpt_type;
        end else if (rm_clear[t]) rmv[t] <= 1'b0;
      end
    end
  end
  assign hit1 = wr_en && wr_thread_id == rd_thread_id && wr_dest == rd_src1_addr;
  assign hit2 = wr_en && wr_thread_id == rd_thread_id && wr_dest == rd_src2_addr;
  assign rd_src1_data = (reset || rd_src1_addr == '0) ? '0 : hit1 ? wr_data : regs[rd_thread_id][rd_src1_addr];
  assign rd_src2_data = (reset || rd_src2_addr == '0) ? '0 : hit2 ? wr_data : regs[rd_thread_id][rd_src2_addr];
  assign rd_src1_pending = !reset && rd_src1_addr != '0 && pend[rd_thread_id][rd_src1_addr] &&
                           !(hit1 && owner[rd_thread_id][rd_src1_addr] == wr_instr_id);
  assign rd_src2_pending = !reset && rd_src2_addr != '0 && pend[rd_thread_id][rd_src2_addr] &&
                           !(hit2 && owner[rd_thread_id][rd_src2_addr] == wr_instr_id);
  assign rd_src1_rob_id = reset ? '0 : owner[rd_thread_id][rd_src1_addr];
  assign rd_src2_rob_id = reset ? '0 : owner[rd_thread_id][rd_src2_addr];
  assign rm_valid = !reset && rmv[rd_thread_id];
  assign rm_pc = reset ? '0 : rmpc[rd_thread_id];
  assign rm_addr = reset ? '0 : rmaddr[rd_thread_id];
  assign rm_type = reset ? '0 : rmtype[rd_thread_id];
endmodule
